// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the alu_sequencer controller.
// Build option ALU_SEQ_SINGLE_STEP_EN adds the PAUSE state for single-step operation.
package alu_seq_pkg;

    localparam int unsigned INSTR_W  = 16;
    localparam int unsigned OPC_MSB  = 15;
    localparam int unsigned OPC_LSB  = 11;
    localparam int unsigned SEL_MSB  = 10;
    localparam int unsigned SEL_LSB  = 8;
    localparam int unsigned ADDR_MSB = 7;
    localparam int unsigned ADDR_LSB = 0;
    localparam int unsigned OPC_W    = OPC_MSB - OPC_LSB + 1;
    localparam int unsigned SEL_W    = SEL_MSB - SEL_LSB + 1;
    localparam int unsigned ADDR_W   = ADDR_MSB - ADDR_LSB + 1;
    localparam int unsigned CLASS_W  = 2;
    localparam int unsigned STATE_W  = 4;

    localparam logic [7:0] RESET_PC_DEFAULT = 8'h00;

    typedef enum logic [CLASS_W-1:0] {
        CLASS_ACC    = 2'b00,
        CLASS_STORE  = 2'b01,
        CLASS_BRANCH = 2'b10,
        CLASS_ACC2   = 2'b11
    } instr_class_e;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEMRD     = 4'd3,
        ST_LOAD      = 4'd4,
        ST_EXECUTE   = 4'd5,
        ST_WRITEBACK = 4'd6,
        ST_HALT      = 4'd7
`ifdef ALU_SEQ_SINGLE_STEP_EN
        ,
        ST_PAUSE     = 4'd8
`endif
    } seq_state_e;

    // Instruction word layout: opcode | selector | data address.
    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [SEL_W-1:0]  sel;
        logic [ADDR_W-1:0] addr;
    } instr_t;

    // Busy covers every state that is part of an instruction in flight.
    function automatic logic state_busy(input seq_state_e s);
        logic idle_like;
        idle_like = (s == ST_IDLE) || (s == ST_HALT);
`ifdef ALU_SEQ_SINGLE_STEP_EN
        idle_like = idle_like || (s == ST_PAUSE);
`endif
        return !idle_like;
    endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational split of the instruction register into its fields and opcode class.
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [INSTR_W-1:0] ir_i,
    output logic [OPC_W-1:0]   opcode_c,
    output logic [SEL_W-1:0]   sel_c,
    output logic [ADDR_W-1:0]  addr_c,
    output instr_class_e       class_c
);

    instr_t instr;

    assign instr    = instr_t'(ir_i);
    assign opcode_c = instr.opcode;
    assign sel_c    = instr.sel;
    assign addr_c   = instr.addr;

    // Class lives in the two most significant opcode bits.
    assign class_c  = instr_class_e'(instr.opcode[OPC_W-1 -: CLASS_W]);

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/decode/execute controller between program ROM, data RAM and the ALU.
// Build option ALU_SEQ_SINGLE_STEP_EN adds StepInput and a PAUSE state after every WRITEBACK.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned      PC_W     = 8,
    parameter int unsigned      DATA_W   = 16,
    parameter logic [PC_W-1:0]  RESET_PC = PC_W'(RESET_PC_DEFAULT)
)(
    input  logic                clkInput,
    input  logic                nResetInput,
    input  logic                StartInput,
`ifdef ALU_SEQ_SINGLE_STEP_EN
    input  logic                StepInput,
`endif
    output logic [PC_W-1:0]     ProgramAddressOutput,
    input  logic [INSTR_W-1:0]  ProgramDataInput,
    output logic [PC_W-1:0]     DataAddressOutput,
    input  logic [DATA_W-1:0]   DataReadInput,
    output logic [DATA_W-1:0]   DataWriteOutput,
    output logic                DataWriteEnableOutput,
    output logic [OPC_W-1:0]    AluOperandOutput,
    output logic [SEL_W-1:0]    AluOutputSelectorOutput,
    output logic [DATA_W-1:0]   AluAccumulatorOutput,
    output logic [DATA_W-1:0]   AluDataOutput,
    output logic                AluConditionFlagOutput,
    input  logic [DATA_W-1:0]   AluAccumulatorInput,
    input  logic [DATA_W-1:0]   AluDataInput,
    input  logic [PC_W-1:0]     AluProgramCounterInput,
    input  logic                AluConditionFlagInput,
    input  logic                AluEndFlagInput,
    output logic                BusyOutput,
    output logic                HaltedOutput
);

    seq_state_e           state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]    mdr_q, mdr_d;
    logic [DATA_W-1:0]    acc_q, acc_d;
    logic                 flag_q, flag_d;
    logic                 we_q, we_d;
    logic                 busy_q, busy_d;
    logic                 halted_q, halted_d;

    logic [OPC_W-1:0]     opcode_c;
    logic [SEL_W-1:0]     sel_c;
    logic [ADDR_W-1:0]    addr_c;
    instr_class_e         class_c;

    alu_seq_decode u_decode (
        .ir_i     (ir_q),
        .opcode_c (opcode_c),
        .sel_c    (sel_c),
        .addr_c   (addr_c),
        .class_c  (class_c)
    );

    // Next-state and datapath updates; each register holds unless its state acts on it.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        mdr_d    = mdr_q;
        acc_d    = acc_q;
        flag_d   = flag_q;
        we_d     = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (StartInput) begin
                    state_d = ST_FETCH;
                    pc_d    = RESET_PC;
                    acc_d   = '0;
                    flag_d  = 1'b0;
                end
            end
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ir_d    = ProgramDataInput;
                state_d = ST_MEMRD;
            end
            ST_MEMRD: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                mdr_d   = DataReadInput;
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                // Strobe is registered so it lines up exactly with WRITEBACK.
                we_d    = (class_c == CLASS_STORE);
                state_d = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                flag_d = AluConditionFlagInput;
                if ((class_c == CLASS_ACC) || (class_c == CLASS_ACC2)) begin
                    acc_d = AluAccumulatorInput;
                end
                // End result wins over any PC update, including a taken branch.
                if (AluEndFlagInput) begin
                    state_d = ST_HALT;
                end else begin
                    if (class_c == CLASS_BRANCH) begin
                        pc_d = AluProgramCounterInput;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
`ifdef ALU_SEQ_SINGLE_STEP_EN
                    state_d = ST_PAUSE;
`else
                    state_d = ST_FETCH;
`endif
                end
            end
`ifdef ALU_SEQ_SINGLE_STEP_EN
            ST_PAUSE: begin
                if (StepInput) begin
                    state_d = ST_FETCH;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d   = state_busy(state_d);
        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clkInput or negedge nResetInput) begin
        if (!nResetInput) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            mdr_q    <= '0;
            acc_q    <= '0;
            flag_q   <= 1'b0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            mdr_q    <= mdr_d;
            acc_q    <= acc_d;
            flag_q   <= flag_d;
            we_q     <= we_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end

    assign ProgramAddressOutput    = pc_q;
    assign DataAddressOutput       = PC_W'(addr_c);
    assign AluOperandOutput        = opcode_c;
    assign AluOutputSelectorOutput = sel_c;
    assign AluAccumulatorOutput    = acc_q;
    assign AluDataOutput           = mdr_q;
    assign AluConditionFlagOutput  = flag_q;
    assign DataWriteEnableOutput   = we_q;
    assign BusyOutput              = busy_q;
    assign HaltedOutput            = halted_q;

    // The ALU result is already registered; gating keeps the write bus quiet outside WRITEBACK.
    assign DataWriteOutput         = we_q ? AluDataInput : '0;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: instruction-level reference model plus directed program scenarios.
`timescale 1ns/1ps
module tb_alu_sequencer;

    localparam logic [7:0]  RST_PC         = 8'h00;
    localparam logic [15:0] ALU_ADD        = 16'h000E;
    localparam logic [15:0] ALU_STORE_DATA = 16'h1234;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        step  = 1'b0;

    logic [7:0]  pa, da;
    logic [15:0] rom_q = '0, ram_q = '0;
    logic [15:0] wd;
    logic        we;
    logic [4:0]  opc_o;
    logic [2:0]  sel_o;
    logic [15:0] acc_o, mdr_o;
    logic        flag_o, busy, halted;
    logic [15:0] alu_acc = '0, alu_data = '0;
    logic [7:0]  alu_pc = '0;
    logic        alu_flag = 1'b0, alu_end = 1'b0;

    logic [15:0] rom [256];
    logic [15:0] ram_init [256];
    logic [15:0] ram_wd [256];
    bit          ram_wv [256];

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state (instruction-level view).
    bit          m_run = 1'b0, m_halt = 1'b0, m_pause = 1'b0;
    int          m_k = 0;
    logic [7:0]  m_pc = RST_PC;
    logic [15:0] m_acc = '0, m_ir = '0, m_opnd = '0;
    logic        m_flag = 1'b0;
    logic [15:0] m_ram_wd [256];
    bit          m_ram_wv [256];

    alu_sequencer dut (
        .clkInput                (clk),
        .nResetInput             (rst_n),
        .StartInput              (start),
`ifdef ALU_SEQ_SINGLE_STEP_EN
        .StepInput               (step),
`endif
        .ProgramAddressOutput    (pa),
        .ProgramDataInput        (rom_q),
        .DataAddressOutput       (da),
        .DataReadInput           (ram_q),
        .DataWriteOutput         (wd),
        .DataWriteEnableOutput   (we),
        .AluOperandOutput        (opc_o),
        .AluOutputSelectorOutput (sel_o),
        .AluAccumulatorOutput    (acc_o),
        .AluDataOutput           (mdr_o),
        .AluConditionFlagOutput  (flag_o),
        .AluAccumulatorInput     (alu_acc),
        .AluDataInput            (alu_data),
        .AluProgramCounterInput  (alu_pc),
        .AluConditionFlagInput   (alu_flag),
        .AluEndFlagInput         (alu_end),
        .BusyOutput              (busy),
        .HaltedOutput            (halted)
    );

    always #5 clk = ~clk;

    // Synchronous ROM and RAM with one-cycle read latency.
    always @(posedge clk) begin
        rom_q <= rom[pa];
        ram_q <= ram_wv[da] ? ram_wd[da] : ram_init[da];
        if (we) begin
            ram_wv[da] <= 1'b1;
            ram_wd[da] <= wd;
        end
    end

    // Registered ALU: acc+data+0xE, fixed store word, branch to data[7:0], flag=sel[0], end when sel=7.
    always @(posedge clk) begin
        alu_acc  <= acc_o + mdr_o + ALU_ADD;
        alu_data <= ALU_STORE_DATA;
        alu_pc   <= mdr_o[7:0];
        alu_flag <= sel_o[0];
        alu_end  <= (sel_o == 3'b111);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_ram_rd(input logic [7:0] a);
        return m_ram_wv[a] ? m_ram_wd[a] : ram_init[a];
    endfunction

    // Six cycles per instruction (k=0 fetch .. k=5 writeback); semantics applied at retirement.
    task automatic model_loop();
        logic [1:0] cls;
        logic [2:0] sel;
        logic [7:0] a;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_run = 1'b0; m_halt = 1'b0; m_pause = 1'b0; m_k = 0;
                m_pc = RST_PC; m_acc = '0; m_flag = 1'b0;
            end else if (m_run) begin
                if (m_k == 5) begin
                    cls = m_ir[15:14];
                    sel = m_ir[10:8];
                    a   = m_ir[7:0];
                    if (cls == 2'b00 || cls == 2'b11) m_acc = m_acc + m_opnd + ALU_ADD;
                    if (cls == 2'b01) begin
                        m_ram_wv[a] = 1'b1;
                        m_ram_wd[a] = ALU_STORE_DATA;
                    end
                    m_flag = sel[0];
                    if (sel == 3'b111) begin
                        m_run  = 1'b0;
                        m_halt = 1'b1;
                    end else begin
                        m_pc = (cls == 2'b10) ? m_opnd[7:0] : m_pc + 8'd1;
                        m_k  = 0;
`ifdef ALU_SEQ_SINGLE_STEP_EN
                        m_run   = 1'b0;
                        m_pause = 1'b1;
`endif
                    end
                end else begin
                    m_k++;
                    if (m_k == 2) m_ir = rom[m_pc];
                    if (m_k == 4) m_opnd = m_ram_rd(m_ir[7:0]);
                end
            end else if (m_pause) begin
                if (step) begin
                    m_pause = 1'b0; m_run = 1'b1; m_k = 0;
                end
            end else if (start) begin
                m_run = 1'b1; m_halt = 1'b0; m_k = 0;
                m_pc = RST_PC; m_acc = '0; m_flag = 1'b0;
            end
        end
    endtask

    task automatic compare_loop();
        logic exp_we;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("pc", 32'(pa), 32'(m_pc));
                chk("busy", 32'(busy), 32'(m_run));
                chk("halted", 32'(halted), 32'(m_halt));
                chk("acc", 32'(acc_o), 32'(m_acc));
                chk("flag", 32'(flag_o), 32'(m_flag));
                exp_we = m_run && (m_k == 5) && (m_ir[15:14] == 2'b01);
                chk("wr_en", 32'(we), 32'(exp_we));
                if (exp_we) chk("wr_data", 32'(wd), 32'(ALU_STORE_DATA));
                if (m_run && m_k >= 2) chk("daddr", 32'(da), 32'(m_ir[7:0]));
                if (m_run && m_k >= 4) begin
                    chk("alu_opc", 32'(opc_o), 32'(m_ir[15:11]));
                    chk("alu_sel", 32'(sel_o), 32'(m_ir[10:8]));
                    chk("alu_data", 32'(mdr_o), 32'(m_opnd));
                end
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic pulse_step();
        @(posedge clk); #1 step = 1'b1;
        @(posedge clk); #1 step = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pc"}, 32'(pa), 32'(8'h00));
        chk({tag, "_busy"}, 32'(busy), 32'(1'b0));
        chk({tag, "_halted"}, 32'(halted), 32'(1'b0));
        chk({tag, "_we"}, 32'(we), 32'(1'b0));
        chk({tag, "_wdata"}, 32'(wd), 32'(16'h0000));
        chk({tag, "_daddr"}, 32'(da), 32'(8'h00));
        chk({tag, "_opc"}, 32'(opc_o), 32'(5'd0));
        chk({tag, "_sel"}, 32'(sel_o), 32'(3'd0));
        chk({tag, "_acc"}, 32'(acc_o), 32'(16'h0000));
        chk({tag, "_mdr"}, 32'(mdr_o), 32'(16'h0000));
        chk({tag, "_flag"}, 32'(flag_o), 32'(1'b0));
    endtask

    initial begin
        // Unprogrammed words are accumulate-and-end so a stray fetch halts.
        for (int i = 0; i < 256; i++) begin
            rom[i]      = 16'h0700;
            ram_init[i] = 16'h0000;
        end
        fork
            model_loop();
            compare_loop();
        join_none

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

`ifndef ALU_SEQ_SINGLE_STEP_EN
        // Accumulate, store to 5, branch to 0x40, branch-with-end.
        rom[8'h00] = 16'h0100;
        rom[8'h01] = 16'h4105;
        rom[8'h02] = 16'h8006;
        rom[8'h40] = 16'h8707;
        ram_init[0] = 16'h0001;
        ram_init[6] = 16'h0040;
        ram_init[7] = 16'h00FF;
        pulse_start();
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk); #1;
            start = (c == 2);
            if (c == 6) begin
                chk("s1_acc", 32'(acc_o), 32'(16'h000F));
                chk("s1_pc", 32'(pa), 32'(8'h01));
            end
            if (c == 11) begin
                chk("s1_store_we", 32'(we), 32'(1'b1));
                chk("s1_store_addr", 32'(da), 32'(8'h05));
                chk("s1_store_data", 32'(wd), 32'(16'h1234));
            end
            if (c == 12) chk("s1_store_we_drop", 32'(we), 32'(1'b0));
            if (c == 18) chk("s1_branch_pc", 32'(pa), 32'(8'h40));
            if (c == 24) begin
                chk("s1_halted", 32'(halted), 32'(1'b1));
                chk("s1_halt_busy", 32'(busy), 32'(1'b0));
                chk("s1_halt_pc", 32'(pa), 32'(8'h40));
                chk("s1_halt_flag", 32'(flag_o), 32'(1'b1));
            end
        end

        // Restart from HALT, branch to 0xFF, wrap to 0x00, end while accumulating.
        rom[8'h00]  = 16'h8008;
        rom[8'hFF]  = 16'h0003;
        ram_init[8] = 16'h00FF;
        ram_init[3] = 16'h0005;
        ram_init[4] = 16'h0010;
        pulse_start();
        chk("s2_restart_pc", 32'(pa), 32'(8'h00));
        chk("s2_restart_acc", 32'(acc_o), 32'(16'h0000));
        chk("s2_restart_flag", 32'(flag_o), 32'(1'b0));
        chk("s2_restart_busy", 32'(busy), 32'(1'b1));
        for (int c = 1; c <= 18; c++) begin
            @(posedge clk); #1;
            if (c == 6) chk("s2_pc_ff", 32'(pa), 32'(8'hFF));
            if (c == 7) rom[8'h00] = 16'h0704;
            if (c == 12) begin
                chk("s2_wrap_pc", 32'(pa), 32'(8'h00));
                chk("s2_wrap_acc", 32'(acc_o), 32'(16'h0013));
            end
            if (c == 18) begin
                chk("s2_end_halted", 32'(halted), 32'(1'b1));
                chk("s2_end_pc", 32'(pa), 32'(8'h00));
                chk("s2_end_acc", 32'(acc_o), 32'(16'h0031));
            end
        end

        // Reset during EXECUTE of a store: no strobe, reset values, RAM untouched.
        rom[8'h00] = 16'h4109;
        pulse_start();
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            if (c == 4) begin
                chk("s3_exec_we", 32'(we), 32'(1'b0));
                rst_n = 1'b0;
            end
            if (c == 5) chk_reset_outputs("s3_rst");
            if (c == 6) rst_n = 1'b1;
            if (c == 7) chk("s3_ram9_unwritten", 32'(ram_wv[9]), 32'(1'b0));
        end
        rom[8'h00] = 16'h0705;
        pulse_start();
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (c == 6) begin
                chk("s3_halted", 32'(halted), 32'(1'b1));
                chk("s3_acc", 32'(acc_o), 32'(16'h1242));
                chk("s3_pc", 32'(pa), 32'(8'h00));
            end
        end
`else
        // Single step: three accumulates then an end, one instruction per Start/Step.
        rom[8'h00] = 16'h0000;
        rom[8'h01] = 16'h0000;
        rom[8'h02] = 16'h0000;
        rom[8'h03] = 16'h0700;
        ram_init[0] = 16'h0001;
        pulse_start();
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c == 6) begin
                chk("ss_pause_busy", 32'(busy), 32'(1'b0));
                chk("ss_pause_halted", 32'(halted), 32'(1'b0));
                chk("ss_pause_pc", 32'(pa), 32'(8'h01));
            end
            if (c == 8) chk("ss_still_paused_pc", 32'(pa), 32'(8'h01));
        end
        for (int s = 0; s < 2; s++) begin
            pulse_step();
            repeat (6) @(posedge clk);
            #1;
        end
        chk("ss_pc3", 32'(pa), 32'(8'h03));
        chk("ss_acc", 32'(acc_o), 32'(16'h002D));
        chk("ss_pc3_busy", 32'(busy), 32'(1'b0));
        pulse_step();
        repeat (6) @(posedge clk);
        #1;
        chk("ss_end_halted", 32'(halted), 32'(1'b1));
        chk("ss_end_pc", 32'(pa), 32'(8'h03));
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
